// File: rtl/alu_ctrl_encoder.sv
// alu_ctrl_encoder: decodes a MIPS instruction into a registered ALU command bundle
// held in a 1-entry valid/ready register with flush and illegal-instruction flagging.
module alu_ctrl_encoder #(
    parameter logic [4:0] ILLEGAL_CTRL = 5'b11111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_control,
    output logic [4:0]  shamt,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    output logic [4:0]  wr_addr,
    output logic        reg_write,
    output logic        use_imm,
    output logic [31:0] imm32,
    output logic        ovf_trap,
    output logic        illegal
);
    logic [5:0]  op, funct;
    logic [4:0]  r_ctrl, i_ctrl, d_ctrl, d_shamt, d_wr;
    logic        r_ok, i_ok, is_r, is_br, legal, d_rw, d_use_imm, d_ovf, sext_op, zext_op;
    logic [31:0] d_imm;
    logic        load;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    always_comb begin
        r_ctrl = ILLEGAL_CTRL;
        r_ok   = 1'b1;
        case (funct)
            6'h00: r_ctrl = 5'd0;
            6'h02: r_ctrl = 5'd1;
            6'h03: r_ctrl = 5'd2;
            6'h04: r_ctrl = 5'd3;
            6'h06: r_ctrl = 5'd4;
            6'h07: r_ctrl = 5'd5;
            6'h20: r_ctrl = 5'd6;
            6'h21: r_ctrl = 5'd7;
            6'h22: r_ctrl = 5'd8;
            6'h23: r_ctrl = 5'd9;
            6'h24: r_ctrl = 5'd10;
            6'h25: r_ctrl = 5'd11;
            6'h26: r_ctrl = 5'd12;
            6'h27: r_ctrl = 5'd13;
            6'h2A: r_ctrl = 5'd14;
            6'h2B: r_ctrl = 5'd15;
            default: r_ok = 1'b0;
        endcase
    end

    // loads, stores and branches reuse the adder/subtractor for address and compare
    always_comb begin
        i_ctrl = ILLEGAL_CTRL;
        i_ok   = 1'b1;
        case (op)
            6'h08: i_ctrl = 5'd6;
            6'h09: i_ctrl = 5'd7;
            6'h0A: i_ctrl = 5'd14;
            6'h0B: i_ctrl = 5'd15;
            6'h0C: i_ctrl = 5'd10;
            6'h0D: i_ctrl = 5'd11;
            6'h0E: i_ctrl = 5'd12;
            6'h0F: i_ctrl = 5'd16;
            6'h23: i_ctrl = 5'd7;
            6'h2B: i_ctrl = 5'd7;
            6'h04: i_ctrl = 5'd9;
            6'h05: i_ctrl = 5'd9;
            default: i_ok = 1'b0;
        endcase
    end

    assign is_r      = op == 6'h00;
    assign is_br     = op == 6'h04 || op == 6'h05;
    assign legal     = is_r ? r_ok : i_ok;
    assign d_ctrl    = !legal ? ILLEGAL_CTRL : is_r ? r_ctrl : i_ctrl;
    assign d_rw      = legal && !is_br && op != 6'h2B;
    assign d_wr      = !d_rw ? 5'd0 : is_r ? instr[15:11] : instr[20:16];
    assign d_use_imm = legal && !is_r && !is_br;
    assign sext_op   = op == 6'h08 || op == 6'h09 || op == 6'h0A || op == 6'h0B || op == 6'h23 || op == 6'h2B;
    assign zext_op   = op == 6'h0C || op == 6'h0D || op == 6'h0E || op == 6'h0F;
    assign d_imm     = sext_op ? {{16{instr[15]}}, instr[15:0]} : zext_op ? {16'h0, instr[15:0]} : 32'h0;
    assign d_shamt   = is_r && (funct == 6'h00 || funct == 6'h02 || funct == 6'h03) ? instr[10:6] : 5'd0;
    assign d_ovf     = is_r ? (funct == 6'h20 || funct == 6'h22) : op == 6'h08;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= 5'd0;
            shamt       <= 5'd0;
            rs_addr     <= 5'd0;
            rt_addr     <= 5'd0;
            wr_addr     <= 5'd0;
            reg_write   <= 1'b0;
            use_imm     <= 1'b0;
            imm32       <= 32'h0;
            ovf_trap    <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            alu_control <= d_ctrl;
            shamt       <= d_shamt;
            rs_addr     <= instr[25:21];
            rt_addr     <= instr[20:16];
            wr_addr     <= d_wr;
            reg_write   <= d_rw;
            use_imm     <= d_use_imm;
            imm32       <= d_imm;
            ovf_trap    <= d_ovf;
            illegal     <= !legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// tb_alu_ctrl_encoder: directed self-checking bench for the decode pipeline register.
module tb_alu_ctrl_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  alu_control, shamt, rs_addr, rt_addr, wr_addr;
    logic        reg_write, use_imm, ovf_trap, illegal;
    logic [31:0] imm32;
    int          checks = 0;
    int          errors = 0;

    alu_ctrl_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_control(alu_control),
        .shamt(shamt), .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr),
        .reg_write(reg_write), .use_imm(use_imm), .imm32(imm32), .ovf_trap(ovf_trap),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  ctrl, shamt, rs, rt, wr;
        logic        rw, ui;
        logic [31:0] imm;
        logic        imm_dc, ovf, ill;
    } vec_t;

    localparam int NDEC = 12;
    vec_t dec_tab [NDEC] = '{
        '{32'h00851020, 5'd6,  5'd0, 5'd4, 5'd5, 5'd2, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0},
        '{32'h00021883, 5'd2,  5'd2, 5'd0, 5'd2, 5'd3, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0},
        '{32'h3C01ABCD, 5'd16, 5'd0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 1'b0},
        '{32'h2021FFFF, 5'd6,  5'd0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0},
        '{32'h3421FFFF, 5'd11, 5'd0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0},
        '{32'hFC000000, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
        '{32'h8C880004, 5'd7,  5'd0, 5'd4, 5'd8, 5'd8, 1'b1, 1'b1, 32'h00000004, 1'b0, 1'b0, 1'b0},
        '{32'hAC880008, 5'd7,  5'd0, 5'd4, 5'd8, 5'd0, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b0, 1'b0},
        '{32'h1085FFFF, 5'd9,  5'd0, 5'd4, 5'd5, 5'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0},
        '{32'h00000000, 5'd0,  5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0},
        '{32'h00000001, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1},
        '{32'h0085102A, 5'd14, 5'd0, 5'd4, 5'd5, 5'd2, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0}
    };

    logic [31:0] str_instr [16] = '{
        32'h00851020, 32'h00851022, 32'h00851024, 32'h00851025, 32'h00851026, 32'h00851027,
        32'h0085102A, 32'h0085102B, 32'h00021880, 32'h00021882, 32'h00021883, 32'h3C01ABCD,
        32'h2021FFFF, 32'h8C880004, 32'hAC880008, 32'hFC000000
    };
    logic [4:0] str_ctrl [16] = '{5'd6, 5'd8, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
                                  5'd0, 5'd1, 5'd2, 5'd16, 5'd6, 5'd7, 5'd7, 5'd31};
    logic [4:0] str_wr [16]   = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2,
                                  5'd3, 5'd3, 5'd3, 5'd1, 5'd1, 5'd8, 5'd0, 5'd0};

    task automatic test_reset;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({alu_control, shamt, rs_addr, rt_addr, wr_addr, reg_write, use_imm, imm32, ovf_trap, illegal} !== 61'h0) begin
            errors++; $display("FAIL reset_fields ctrl %h wr %h imm %h ill %b want all 0", alu_control, wr_addr, imm32, illegal);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
    endtask

    task automatic test_decode;
        for (int i = 0; i < NDEC; i++) begin
            @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; instr = dec_tab[i].instr;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec%0d valid got %b want 1", i, out_valid); end
            checks++; if (alu_control !== dec_tab[i].ctrl) begin errors++; $display("FAIL dec%0d ctrl got %h want %h", i, alu_control, dec_tab[i].ctrl); end
            checks++; if (shamt !== dec_tab[i].shamt) begin errors++; $display("FAIL dec%0d shamt got %h want %h", i, shamt, dec_tab[i].shamt); end
            checks++; if (rs_addr !== dec_tab[i].rs) begin errors++; $display("FAIL dec%0d rs got %h want %h", i, rs_addr, dec_tab[i].rs); end
            checks++; if (rt_addr !== dec_tab[i].rt) begin errors++; $display("FAIL dec%0d rt got %h want %h", i, rt_addr, dec_tab[i].rt); end
            checks++; if (wr_addr !== dec_tab[i].wr) begin errors++; $display("FAIL dec%0d wr got %h want %h", i, wr_addr, dec_tab[i].wr); end
            checks++; if (reg_write !== dec_tab[i].rw) begin errors++; $display("FAIL dec%0d reg_write got %b want %b", i, reg_write, dec_tab[i].rw); end
            checks++; if (use_imm !== dec_tab[i].ui) begin errors++; $display("FAIL dec%0d use_imm got %b want %b", i, use_imm, dec_tab[i].ui); end
            if (!dec_tab[i].imm_dc) begin
                checks++; if (imm32 !== dec_tab[i].imm) begin errors++; $display("FAIL dec%0d imm32 got %h want %h", i, imm32, dec_tab[i].imm); end
            end
            checks++; if (ovf_trap !== dec_tab[i].ovf) begin errors++; $display("FAIL dec%0d ovf_trap got %b want %b", i, ovf_trap, dec_tab[i].ovf); end
            checks++; if (illegal !== dec_tab[i].ill) begin errors++; $display("FAIL dec%0d illegal got %b want %b", i, illegal, dec_tab[i].ill); end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain valid got %b want 0", out_valid); end
    endtask

    task automatic test_stall;
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b1; instr = 32'h00851020;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || alu_control !== 5'd6) begin errors++; $display("FAIL stall_load valid %b ctrl %h want 1 06", out_valid, alu_control); end
        @(negedge clk); out_ready = 1'b0; instr = 32'h00851022;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d in_ready got %b want 0", k, in_ready); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || alu_control !== 5'd6 || wr_addr !== 5'd2) begin
                errors++; $display("FAIL stall%0d hold valid %b ctrl %h wr %h want 1 06 02", k, out_valid, alu_control, wr_addr);
            end
            @(negedge clk);
        end
        out_ready = 1'b1; #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || alu_control !== 5'd8) begin errors++; $display("FAIL release_next valid %b ctrl %h want 1 08", out_valid, alu_control); end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_nodup valid got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b0; instr = 32'h00851020;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_held valid got %b want 1", out_valid); end
        @(negedge clk); instr = 32'h00851022; flush = 1'b1; #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill valid got %b want 0", out_valid); end
        checks++; if (alu_control !== 5'd6) begin errors++; $display("FAIL flush_keep ctrl got %h want 06", alu_control); end
        @(negedge clk); out_ready = 1'b1; #1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || alu_control !== 5'd6) begin errors++; $display("FAIL flush_incoming valid %b ctrl %h want 0 06", out_valid, alu_control); end
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_stall;
        @(negedge clk); in_valid = 1'b1; out_ready = 1'b0; instr = 32'h3C01ABCD;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || alu_control !== 5'd16) begin errors++; $display("FAIL rst_stall_load valid %b ctrl %h want 1 10", out_valid, alu_control); end
        @(negedge clk); in_valid = 1'b0; #2; rst_n = 1'b0; #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async valid got %b want 0", out_valid); end
        checks++; if (alu_control !== 5'd0 || imm32 !== 32'h0 || reg_write !== 1'b0) begin
            errors++; $display("FAIL rst_async_fields ctrl %h imm %h rw %b want 0", alu_control, imm32, reg_write);
        end
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard valid got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); in_valid = 1'b1; instr = str_instr[i];
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || alu_control !== str_ctrl[i] || wr_addr !== str_wr[i]) begin
                errors++; $display("FAIL b2b%0d valid %b ctrl %h wr %h want 1 %h %h", i, out_valid, alu_control, wr_addr, str_ctrl[i], str_wr[i]);
            end
        end
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain valid got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset;
        test_decode;
        test_stall;
        test_flush;
        test_reset_mid_stall;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
